// File: rtl/fft_bitrev_loader.sv
// Bit-reversed input staging buffer for an in-place radix-2 DIT FFT.
// Define FFT_BITREV_PINGPONG_EN for two banks (capture overlaps drain); default is one bank.
module fft_bitrev_loader #(
    parameter int log2Ns = 10,
    parameter int Nbits  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [Nbits-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [Nbits-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [log2Ns-1:0] out_idx,
    output logic              out_last,
    output logic              idle
);

    localparam int N = 1 << log2Ns;
`ifdef FFT_BITREV_PINGPONG_EN
    localparam int NB = 2;
    localparam int AW = log2Ns + 1;
    localparam bit PP = 1'b1;
`else
    localparam int NB = 1;
    localparam int AW = log2Ns;
    localparam bit PP = 1'b0;
`endif
    localparam logic [log2Ns-1:0] CNT_LAST = {log2Ns{1'b1}};
    localparam logic [log2Ns-1:0] CNT_ONE  = {{(log2Ns-1){1'b0}}, 1'b1};

    typedef enum logic {W_FILL, W_WAIT} wstate_t;
    typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

    function automatic logic [log2Ns-1:0] bitrev(input logic [log2Ns-1:0] k);
        logic [log2Ns-1:0] r;
        for (int i = 0; i < log2Ns; i++) r[i] = k[log2Ns-1-i];
        return r;
    endfunction

    logic [Nbits-1:0]  mem [NB*N];
    logic [AW-1:0]     waddr, raddr;
    logic [Nbits-1:0]  rd_word;

    wstate_t           wstate, wstate_nxt;
    rstate_t           rstate, rstate_nxt;
    logic              run;
    logic [log2Ns-1:0] wr_cnt, rd_cnt;
    logic              wbank, wbank_nxt, rbank, rbank_nxt;
    logic [1:0]        full, full_nxt;
    logic              rd_done;
    logic              skid_vld;
    logic [Nbits-1:0]  skid_data;
    logic [log2Ns-1:0] skid_idx;
    logic              skid_last;
    logic              wr_fire, wr_end, rd_issue, last_fire;

`ifdef FFT_BITREV_PINGPONG_EN
    assign waddr = {wbank, bitrev(wr_cnt)};
    assign raddr = {rbank, rd_cnt};
`else
    assign waddr = bitrev(wr_cnt);
    assign raddr = rd_cnt;
`endif

    assign rd_word   = mem[raddr];
    assign in_ready  = run & (wstate == W_FILL);
    assign wr_fire   = in_valid & in_ready;
    assign wr_end    = wr_fire & (wr_cnt == CNT_LAST);
    // Reads stop once the skid holds a word, so no issued word is ever dropped.
    assign rd_issue  = (rstate == R_DRAIN) & ~rd_done & ~skid_vld;
    assign last_fire = out_valid & out_ready & out_last;
    assign idle      = ~|full & (wr_cnt == '0) & ~out_valid & ~skid_vld;

    always_comb begin
        full_nxt   = full;
        wbank_nxt  = wbank;
        rbank_nxt  = rbank;
        wstate_nxt = wstate;
        rstate_nxt = rstate;
        if (last_fire) full_nxt[rbank] = 1'b0;
        if (wr_end) full_nxt[wbank] = 1'b1;
        if (wr_end && PP) wbank_nxt = ~wbank;
        if (last_fire && PP) rbank_nxt = ~rbank;

        case (wstate)
            W_FILL: if (wr_end && full_nxt[wbank_nxt]) wstate_nxt = W_WAIT;
            W_WAIT: if (!full_nxt[wbank]) wstate_nxt = W_FILL;
            default: wstate_nxt = W_FILL;
        endcase

        case (rstate)
            R_IDLE:  if (full[rbank]) rstate_nxt = R_DRAIN;
            R_DRAIN: if (last_fire) rstate_nxt = full_nxt[rbank_nxt] ? R_DRAIN : R_IDLE;
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run     <= 1'b0;
            wstate  <= W_FILL;
            rstate  <= R_IDLE;
            wbank   <= 1'b0;
            rbank   <= 1'b0;
            full    <= 2'b00;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            rd_done <= 1'b0;
        end else begin
            run    <= 1'b1;
            wstate <= wstate_nxt;
            rstate <= rstate_nxt;
            wbank  <= wbank_nxt;
            rbank  <= rbank_nxt;
            full   <= full_nxt;
            if (wr_fire) wr_cnt <= wr_cnt + CNT_ONE;
            if (rd_issue) rd_cnt <= rd_cnt + CNT_ONE;
            if (rd_issue && rd_cnt == CNT_LAST) rd_done <= 1'b1;
            else if (last_fire) rd_done <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[waddr] <= in_data;
    end

    // Output register backed by a one-entry skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            skid_vld  <= 1'b0;
        end else if (rd_issue) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_data  <= rd_word;
                out_idx   <= rd_cnt;
                out_last  <= (rd_cnt == CNT_LAST);
            end else begin
                skid_vld <= 1'b1;
            end
        end else if (out_ready) begin
            if (skid_vld) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
                out_idx   <= skid_idx;
                out_last  <= skid_last;
                skid_vld  <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_issue && out_valid && !out_ready) begin
            skid_data <= rd_word;
            skid_idx  <= rd_cnt;
            skid_last <= (rd_cnt == CNT_LAST);
        end
    end

endmodule
